// File: rtl/avg_sched_pkg.sv
// Shared types, widths and helpers for the two-channel averaging scheduler.
// Build option: AVG_ROUND_EN selects round-half-up with saturation instead of truncation.
package avg_sched_pkg;
  localparam int VAL_RES  = 16;
  localparam int LOG2_MAX = 8;
  localparam int ACC_W    = VAL_RES + LOG2_MAX;
  localparam int CNT_W    = LOG2_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic [3:0] clamp_log2n(input logic [3:0] v);
    return (v > 4'(LOG2_MAX)) ? 4'(LOG2_MAX) : v;
  endfunction
endpackage

// File: rtl/avg_sched_if.sv
// Config, sample-input and result handshake bundle for avg_sched.
interface avg_sched_if;
  import avg_sched_pkg::*;
  logic               cfg_en;
  logic [3:0]         cfg_log2n;
  logic [VAL_RES-1:0] ch0_val;
  logic               ch0_valid;
  logic               ch0_ready;
  logic [VAL_RES-1:0] ch1_val;
  logic               ch1_valid;
  logic               ch1_ready;
  logic [VAL_RES-1:0] avg_val;
  logic               avg_ch;
  logic               avg_valid;
  logic               avg_ready;
  logic               busy;

  modport slave (
    input  cfg_en, cfg_log2n, ch0_val, ch0_valid, ch1_val, ch1_valid, avg_ready,
    output ch0_ready, ch1_ready, avg_val, avg_ch, avg_valid, busy
  );
  modport master (
    output cfg_en, cfg_log2n, ch0_val, ch0_valid, ch1_val, ch1_valid, avg_ready,
    input  ch0_ready, ch1_ready, avg_val, avg_ch, avg_valid, busy
  );
endinterface

// File: rtl/avg_acc_lane.sv
// One channel's window accumulator and sample counter; o_cmpl flags that the next add closes the window.
// Build option: AVG_ROUND_EN rounds half-up and saturates the mean.
module avg_acc_lane
  import avg_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_add,
  input  logic               i_clr,
  input  logic [VAL_RES-1:0] i_val,
  input  logic [3:0]         i_n,
  output logic               o_cmpl,
  output logic [VAL_RES-1:0] o_res
);
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_last;

  assign w_last = CNT_W'((1 << i_n) - 1);
  assign o_cmpl = (r_cnt == w_last);
  assign w_sum  = r_acc + ACC_W'(i_val);

`ifdef AVG_ROUND_EN
  logic [ACC_W-1:0] w_half;
  logic [ACC_W-1:0] w_rnd;
  // Sum plus half-LSB cannot exceed ACC_W bits, so only the final mean needs clamping.
  assign w_half = (i_n == 4'd0) ? '0 : (ACC_W'(1) << (i_n - 4'd1));
  assign w_rnd  = (w_sum + w_half) >> i_n;
  assign o_res  = (w_rnd > ACC_W'({VAL_RES{1'b1}})) ? '1 : w_rnd[VAL_RES-1:0];
`else
  assign o_res  = VAL_RES'(w_sum >> i_n);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      if (o_cmpl) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/avg_sched.sv
// Two-channel averaging scheduler: round-robin arbiter over two lanes feeding one result register.
// Build option: AVG_ROUND_EN (rounded/saturated mean) is handled inside avg_acc_lane.
module avg_sched
  import avg_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  avg_sched_if.slave  bus
);
  state_t                   r_state, w_state_nx;
  logic [3:0]               r_n;
  logic                     r_rr;
  logic                     r_avg_valid;
  logic                     r_avg_ch;
  logic [VAL_RES-1:0]       r_avg_val;

  logic [1:0]               w_valid, w_cmpl, w_stall, w_elig, w_grant;
  logic [1:0][VAL_RES-1:0]  w_val, w_res;
  logic                     w_run, w_take, w_done, w_gch;

  assign w_valid = {bus.ch1_valid, bus.ch0_valid};
  assign w_val   = {bus.ch1_val, bus.ch0_val};
  assign w_run   = (r_state == RUN);
  assign w_take  = r_avg_valid & bus.avg_ready;
  // A lane may only close its window if the result register is free or being emptied now.
  assign w_stall = w_cmpl & {2{r_avg_valid & ~bus.avg_ready}};
  assign w_elig  = w_valid & ~w_stall & {2{w_run}};

  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) w_grant = r_rr ? 2'b01 : 2'b10;
  end

  assign w_gch  = w_grant[1];
  assign w_done = |(w_grant & w_cmpl);

  for (genvar c = 0; c < 2; c++) begin : g_lane
    avg_acc_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_add  (w_grant[c]),
      .i_clr  (~w_run),
      .i_val  (w_val[c]),
      .i_n    (r_n),
      .o_cmpl (w_cmpl[c]),
      .o_res  (w_res[c])
    );
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (bus.cfg_en)                w_state_nx = RUN;
      RUN:     if (!bus.cfg_en)               w_state_nx = DRAIN;
      DRAIN:   if (!r_avg_valid || w_take)    w_state_nx = IDLE;
      default:                                w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_rr        <= 1'b0;
      r_avg_valid <= 1'b0;
      r_avg_ch    <= 1'b0;
      r_avg_val   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && bus.cfg_en) r_n <= clamp_log2n(bus.cfg_log2n);
      if (|w_grant) r_rr <= w_gch;
      if (w_done) begin
        r_avg_valid <= 1'b1;
        r_avg_val   <= w_res[w_gch];
        r_avg_ch    <= w_gch;
      end else if (w_take) begin
        r_avg_valid <= 1'b0;
      end
    end
  end

  assign bus.ch0_ready = w_grant[0];
  assign bus.ch1_ready = w_grant[1];
  assign bus.avg_valid = r_avg_valid;
  assign bus.avg_val   = r_avg_val;
  assign bus.avg_ch    = r_avg_ch;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_avg_sched.sv
// Bench for avg_sched: window-level reference model checked every cycle, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_avg_sched;
  import avg_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avg_sched_if bus();
  avg_sched dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Mean of a completed window as the datasheet defines it.
  function automatic int mean_of(input longint s, input int n);
    longint mx, r;
    mx = (longint'(1) << VAL_RES) - 1;
`ifdef AVG_ROUND_EN
    if (n == 0) return int'(s & mx);
    r = (s + (longint'(1) << (n - 1))) >> n;
    return int'((r > mx) ? mx : r);
`else
    r = s >> n;
    return int'(r & mx);
`endif
  endfunction

  // Reference state: 0 idle, 1 running, 2 draining.
  int     m_st, m_n, m_rr, m_av, m_aval, m_ach;
  int     m_cnt [2];
  longint m_sum [2];
  int     q_val [$];
  int     q_ch  [$];
  int     e_vld [2];
  int     e_val [2];
  int     e_cmp [2];
  int     e_el  [2];
  int     e_g, e_take, e_av_old;
  longint e_s;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_avg_valid", bus.avg_valid, 0);
      chk("rst_avg_val",   bus.avg_val,   0);
      chk("rst_avg_ch",    bus.avg_ch,    0);
      chk("rst_ch0_ready", bus.ch0_ready, 0);
      chk("rst_ch1_ready", bus.ch1_ready, 0);
      chk("rst_busy",      bus.busy,      0);
      m_st = 0; m_n = 0; m_rr = 0; m_av = 0; m_aval = 0; m_ach = 0;
      m_cnt = '{0, 0}; m_sum = '{0, 0};
    end else begin
      e_vld[0] = bus.ch0_valid; e_vld[1] = bus.ch1_valid;
      e_val[0] = bus.ch0_val;   e_val[1] = bus.ch1_val;
      for (int c = 0; c < 2; c++) begin
        e_cmp[c] = (m_cnt[c] == (1 << m_n) - 1);
        e_el[c]  = (m_st == 1) && e_vld[c] && !(e_cmp[c] && m_av && !bus.avg_ready);
      end
      e_g = -1;
      if (e_el[0] && e_el[1]) e_g = 1 - m_rr;
      else if (e_el[0])       e_g = 0;
      else if (e_el[1])       e_g = 1;

      chk("avg_valid", bus.avg_valid, m_av);
      if (m_av != 0) begin
        chk("avg_val", bus.avg_val, m_aval);
        chk("avg_ch",  bus.avg_ch,  m_ach);
      end
      chk("ch0_ready", bus.ch0_ready, e_g == 0);
      chk("ch1_ready", bus.ch1_ready, e_g == 1);
      chk("busy",      bus.busy,      m_st != 0);
      if (bus.avg_valid && bus.avg_ready) begin
        q_val.push_back(int'(bus.avg_val));
        q_ch.push_back(int'(bus.avg_ch));
      end

      e_av_old = m_av;
      e_take   = m_av && bus.avg_ready;
      if (e_take) m_av = 0;
      if (e_g >= 0) begin
        m_rr = e_g;
        e_s  = m_sum[e_g] + e_val[e_g];
        if (e_cmp[e_g]) begin
          m_av = 1; m_aval = mean_of(e_s, m_n); m_ach = e_g;
          m_sum[e_g] = 0; m_cnt[e_g] = 0;
        end else begin
          m_sum[e_g] = e_s; m_cnt[e_g]++;
        end
      end
      case (m_st)
        0: if (bus.cfg_en) begin
             m_st = 1;
             m_n  = (bus.cfg_log2n > LOG2_MAX) ? LOG2_MAX : int'(bus.cfg_log2n);
           end
        1: if (!bus.cfg_en) begin
             m_st = 2; m_sum = '{0, 0}; m_cnt = '{0, 0};
           end
        default: if (!e_av_old || e_take) m_st = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input int n);
    bus.cfg_log2n = 4'(n);
    bus.cfg_en    = 1'b1;
    tick();
  endtask

  task automatic stop();
    int k;
    bus.ch0_valid = 1'b0; bus.ch1_valid = 1'b0;
    bus.cfg_en = 1'b0; bus.avg_ready = 1'b1;
    k = 0;
    tick();
    while (bus.busy && k < 50) begin tick(); k++; end
    chk("stop_idle", bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1;
  endtask

  task automatic send(input int c, input int v);
    bit ok;
    ok = 1'b0;
    if (c == 0) begin bus.ch0_val = 16'(v); bus.ch0_valid = 1'b1; end
    else        begin bus.ch1_val = 16'(v); bus.ch1_valid = 1'b1; end
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); #1;
      ok = (c == 0) ? bus.ch0_ready : bus.ch1_ready;
      tick();
    end
    if (c == 0) bus.ch0_valid = 1'b0; else bus.ch1_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  int base;
  bit a0, a1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_en = 0; bus.cfg_log2n = 0; bus.avg_ready = 0;
    bus.ch0_val = 0; bus.ch0_valid = 0; bus.ch1_val = 0; bus.ch1_valid = 0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    // n=2 single stream: 4,8,12,16 -> 10 on ch0, one cycle after the last accept
    base = q_val.size();
    bus.avg_ready = 1'b1;
    go(2);
    send(0, 4); send(0, 8); send(0, 12); send(0, 16);
    chk("t1_valid", bus.avg_valid, 1);
    chk("t1_val",   bus.avg_val,   10);
    chk("t1_ch",    bus.avg_ch,    0);
    tick();
    chk("t1_count", q_val.size() - base, 1);
    stop();

    // n=1, both channels always valid: ch1 granted first, results alternate 200/100
    do_reset();
    base = q_val.size();
    bus.avg_ready = 1'b1;
    go(1);
    bus.ch0_val = 100; bus.ch1_val = 200; bus.ch0_valid = 1; bus.ch1_valid = 1;
    #1;
    chk("t2_first_ch1", bus.ch1_ready, 1);
    chk("t2_first_ch0", bus.ch0_ready, 0);
    repeat (8) tick();
    bus.ch0_valid = 0; bus.ch1_valid = 0;
    tick(); tick();
    chk("t2_count", q_val.size() - base, 4);
    if (q_val.size() - base >= 4) begin
      chk("t2_r0", q_val[base],   200); chk("t2_c0", q_ch[base],   1);
      chk("t2_r1", q_val[base+1], 100); chk("t2_c1", q_ch[base+1], 0);
      chk("t2_r2", q_val[base+2], 200); chk("t2_r3", q_val[base+3], 100);
    end
    stop();

    // n=0 with downstream blocked: both channels stall until avg_ready rises
    base = q_val.size();
    go(0);
    bus.avg_ready = 1'b0;
    bus.ch0_val = 7; bus.ch0_valid = 1;
    tick();
    chk("t3_held_valid", bus.avg_valid, 1);
    chk("t3_ch0_stall",  bus.ch0_ready, 0);
    bus.ch1_val = 9; bus.ch1_valid = 1;
    #1;
    chk("t3_ch1_stall",  bus.ch1_ready, 0);
    tick(); tick();
    chk("t3_still_held", bus.avg_val, 7);
    bus.avg_ready = 1'b1;
    #1;
    chk("t3_resume_ch1", bus.ch1_ready, 1);
    repeat (4) tick();
    bus.ch0_valid = 0; bus.ch1_valid = 0;
    tick();
    if (q_val.size() - base >= 2) begin
      chk("t3_r0", q_val[base],   7); chk("t3_c0", q_ch[base],   0);
      chk("t3_r1", q_val[base+1], 9); chk("t3_c1", q_ch[base+1], 1);
    end else chk("t3_count", q_val.size() - base, 2);
    stop();

    // partial window discarded on disable, then a fresh n=1 run: 6,2 -> 4
    base = q_val.size();
    bus.avg_ready = 1'b1;
    go(3);
    for (int i = 1; i <= 5; i++) send(0, i);
    stop();
    chk("t4_no_result", q_val.size() - base, 0);
    go(1);
    send(0, 6); send(0, 2);
    chk("t4_val", bus.avg_val, 4);
    chk("t4_vld", bus.avg_valid, 1);
    stop();

    // asynchronous reset mid-window with a pending result
    bus.avg_ready = 1'b0;
    go(2);
    for (int i = 0; i < 4; i++) send(0, 1);
    send(1, 50);
    bus.ch0_valid = 1; bus.ch0_val = 3;
    #1;
    chk("t5_pre_valid", bus.avg_valid, 1);
    chk("t5_pre_ready", bus.ch0_ready, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_avg_valid", bus.avg_valid, 0);
    chk("t5_avg_val",   bus.avg_val,   0);
    chk("t5_ch0_ready", bus.ch0_ready, 0);
    chk("t5_busy",      bus.busy,      0);
    bus.ch0_valid = 0; bus.cfg_en = 0;
    tick(); #2; rst = 1'b1;
    tick();
    bus.avg_ready = 1'b1;
    go(2);
    send(0, 4); send(0, 8); send(0, 12); send(0, 16);
    chk("t5_after_val", bus.avg_val, 10);
    stop();

    // rounding / saturation corner at n=1
    go(1);
    send(0, 3); send(0, 4);
`ifdef AVG_ROUND_EN
    chk("t6_round", bus.avg_val, 4);
`else
    chk("t6_trunc", bus.avg_val, 3);
`endif
    send(1, 16'hFFFF); send(1, 16'hFFFF);
    chk("t6_max", bus.avg_val, 16'hFFFF);
    stop();

    // random traffic; offered samples are held until accepted
    for (int s = 0; s < 5; s++) begin
      go($urandom_range(0, 15));
      for (int i = 0; i < 500; i++) begin
        @(negedge clk); #1;
        a0 = bus.ch0_valid & bus.ch0_ready;
        a1 = bus.ch1_valid & bus.ch1_ready;
        tick();
        if (!bus.ch0_valid || a0) begin
          bus.ch0_valid = ($urandom_range(0, 3) != 0);
          bus.ch0_val   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        end
        if (!bus.ch1_valid || a1) begin
          bus.ch1_valid = ($urandom_range(0, 3) != 0);
          bus.ch1_val   = 16'($urandom);
        end
        bus.avg_ready = ($urandom_range(0, 9) < 7);
      end
      stop();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
